dualmem_req_bridge: RTL and testbench

DUALMEM_REQ_BRIDGE -- requirements
Module: dualmem_req_bridge

---
 rtl/dualmem_req_bridge.sv | 104 ++++++++++
 tb/tb_dualmem_req_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualmem_req_bridge.sv
// Request bridge between a valid/ready request port and a one-cycle-latency byte-lane RAM.
// Each accepted request produces exactly one response, returned in order through a 3-entry FIFO.
module dualmem_req_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [12:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [63:0] rsp_rdata,
  output logic [7:0]  mem_en,
  output logic [7:0]  mem_we,
  output logic [12:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  logic        inflight;
  logic        inflight_we;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [1:0]  fifo_count;
  logic [64:0] fifo_q [3];

  logic        acc;
  logic        push;
  logic        pop;
  logic [2:0]  credits;
  logic [64:0] push_entry;
  logic [1:0]  wr_ptr_nxt;
  logic [1:0]  rd_ptr_nxt;
  logic [1:0]  count_nxt;
  logic [64:0] head_nxt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count every request not yet handed back, so the FIFO can never overflow.
  assign credits   = {1'b0, fifo_count} + {2'b00, inflight};
  assign req_ready = ~rst & (credits < 3'd3);
  assign acc       = req_valid & req_ready;

  assign push       = inflight;
  assign pop        = rsp_valid & rsp_ready;
  assign push_entry = {inflight_we, inflight_we ? 64'h0 : mem_rdata};
  assign rsp_valid  = (fifo_count != 2'd0);

  always_comb begin
    mem_en    = 8'h00;
    mem_we    = 8'h00;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (acc) begin
      mem_en = req_we ? req_be : 8'hFF;
      mem_we = req_we ? req_be : 8'h00;
    end
  end

  // Next head is computed ahead so rsp_we/rsp_rdata come straight from flops.
  always_comb begin
    wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = fifo_count + 2'(push) - 2'(pop);
    head_nxt   = {rsp_we, rsp_rdata};
    if (count_nxt != 2'd0) begin
      if (push && (wr_ptr == rd_ptr_nxt))
        head_nxt = push_entry;
      else
        head_nxt = fifo_q[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      fifo_count  <= 2'd0;
      rsp_we      <= 1'b0;
      rsp_rdata   <= 64'h0;
    end else begin
      inflight    <= acc;
      inflight_we <= req_we;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      fifo_count  <= count_nxt;
      {rsp_we, rsp_rdata} <= head_nxt;
    end
  end

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_dualmem_req_bridge.sv
// Bench for dualmem_req_bridge: byte-lane RAM model behind the memory port and a
// queue-based reference model of outstanding requests and their responses.
module tb_dualmem_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [12:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [63:0] rsp_rdata;
  logic [7:0]  mem_en;
  logic [7:0]  mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  dualmem_req_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM behind the bridge: 16 words, byte write enables, one-cycle read latency.
  logic [63:0] ram [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = 4'd0;
  logic [63:0] pl_data = 64'h0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (|mem_en) begin
      for (int i = 0; i < 8; i++)
        if (mem_we[i]) ram[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr[3:0]];
    end
  end

  // Reference model: memory image plus queue of accepted-but-unconsumed requests.
  typedef struct {
    logic        we;
    logic [63:0] data;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_mem [0:15];
  int          now = 0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] PRE5 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] PRE7 = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] PRE3 = 64'hA5A50F0F_3C3C9696;

  logic        o_ready, o_acc, o_rv, o_rwe;
  logic [7:0]  o_en, o_mwe;
  logic [12:0] o_maddr;
  logic [63:0] o_mwd, o_rd;
  logic        e_ready, e_acc, e_rv, e_we;
  logic [63:0] e_rd;
  int          e_size;

  // One cycle: drive inputs at negedge, sample, then advance the model across the next rising edge.
  task automatic tick(input logic r, input logic v, input logic we, input logic [12:0] a,
                      input logic [63:0] wd, input logic [7:0] be, input logic rr);
    @(negedge clk);
    rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    rsp_ready = rr;
    #1;
    o_ready = req_ready; o_acc = req_valid && req_ready; o_rv = rsp_valid;
    o_rwe = rsp_we; o_rd = rsp_rdata; o_en = mem_en; o_mwe = mem_we;
    o_maddr = mem_addr; o_mwd = mem_wdata;
    e_size  = q.size();
    e_ready = !r && (e_size < 3);
    e_acc   = v && e_ready;
    e_rv    = (e_size > 0) && (q[0].t + 2 <= now);
    e_we    = (e_size > 0) ? q[0].we : 1'b0;
    e_rd    = (e_size > 0) ? q[0].data : 64'h0;
    if (r) begin
      q.delete();
    end else begin
      if (e_rv && rr) void'(q.pop_front());
      if (e_acc) begin
        if (we) begin
          for (int i = 0; i < 8; i++)
            if (be[i]) ref_mem[a[3:0]][8*i +: 8] = wd[8*i +: 8];
          q.push_back('{we: 1'b1, data: 64'h0, t: now});
        end else begin
          q.push_back('{we: 1'b0, data: ref_mem[a[3:0]], t: now});
        end
      end
    end
    now++;
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, 1'b0, 1'b0, 13'd0, 64'h0, 8'h00, rr);
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 4'(i);
      pl_data = (i == 5) ? PRE5 : (i == 7) ? PRE7 : (i == 3) ? PRE3 : {$urandom, $urandom};
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain: outstanding=%0d required=0", q.size()); end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0, 13'd5, 64'h0, 8'h00, 1'b1);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", o_ready); end
    checks++; if (o_en !== 8'h00 || o_mwe !== 8'h00) begin errors++; $display("FAIL rst_mem: en=%h we=%h want 00", o_en, o_mwe); end
    tick(1'b1, 1'b1, 1'b1, 13'd5, 64'h0, 8'hFF, 1'b1);
    checks++; if (o_rv !== 1'b0 || o_rwe !== 1'b0 || o_rd !== 64'h0) begin errors++; $display("FAIL rst_rsp: v=%b we=%b rd=%h want 0", o_rv, o_rwe, o_rd); end
    checks++; if (o_en !== 8'h00) begin errors++; $display("FAIL rst_mem_en2: got %h want 00", o_en); end
    idle(1'b1);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_single_read();
    tick(1'b0, 1'b1, 1'b0, 13'd5, 64'h0, 8'h00, 1'b1);
    checks++; if (o_acc !== 1'b1 || o_en !== 8'hFF || o_mwe !== 8'h00 || o_maddr !== 13'd5) begin
      errors++; $display("FAIL read_issue: acc=%b en=%h we=%h addr=%0d want 1 FF 00 5", o_acc, o_en, o_mwe, o_maddr); end
    idle(1'b1);
    checks++; if (o_rv !== 1'b0) begin errors++; $display("FAIL read_lat1: rsp_valid=%b want 0", o_rv); end
    idle(1'b1);
    checks++; if (o_rv !== 1'b1 || o_rwe !== 1'b0 || o_rd !== PRE5) begin
      errors++; $display("FAIL read_rsp: v=%b we=%b rd=%h want 1 0 %h", o_rv, o_rwe, o_rd, PRE5); end
  endtask

  task automatic test_byte_write();
    int n = 0;
    tick(1'b0, 1'b1, 1'b1, 13'd7, 64'h11223344_55667788, 8'h0F, 1'b1);
    checks++; if (o_en !== 8'h0F || o_mwe !== 8'h0F || o_mwd !== 64'h11223344_55667788) begin
      errors++; $display("FAIL bw_issue: en=%h we=%h wd=%h want 0F 0F 1122334455667788", o_en, o_mwe, o_mwd); end
    tick(1'b0, 1'b1, 1'b0, 13'd7, 64'h0, 8'h00, 1'b1);
    checks++; if (o_acc !== 1'b1) begin errors++; $display("FAIL bw_read_acc: got %b want 1", o_acc); end
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      if (o_rv) begin
        if (n == 0) begin
          checks++; if (o_rwe !== 1'b1 || o_rd !== 64'h0) begin errors++; $display("FAIL bw_rsp0: we=%b rd=%h want 1 0", o_rwe, o_rd); end
        end else begin
          checks++; if (o_rwe !== 1'b0 || o_rd !== 64'hFFFFFFFF_55667788) begin
            errors++; $display("FAIL bw_rsp1: we=%b rd=%h want 0 FFFFFFFF55667788", o_rwe, o_rd); end
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL bw_count: got %0d want 2", n); end
  endtask

  task automatic test_backpressure();
    int idx = 0, n = 0;
    logic [64:0] held = '0;
    logic have = 1'b0, stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, idx < 5, 1'b0, 13'(8 + idx), 64'h0, 8'h00, 1'b0);
      if (o_acc) idx++;
      if (o_rv) begin
        if (have && {o_rwe, o_rd} !== held) stable = 1'b0;
        held = {o_rwe, o_rd}; have = 1'b1;
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", idx); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", o_ready); end
    checks++; if (!stable || !have || held !== {1'b0, ref_mem[8]}) begin
      errors++; $display("FAIL bp_hold: stable=%b head=%h want %h", stable, held[63:0], ref_mem[8]); end
    for (int i = 0; i < 20 && n < 5; i++) begin
      tick(1'b0, idx < 5, 1'b0, 13'(8 + idx), 64'h0, 8'h00, 1'b1);
      if (o_acc) idx++;
      if (o_rv) begin
        checks++; if (!e_rv || o_rwe !== e_we || o_rd !== e_rd) begin
          errors++; $display("FAIL bp_rsp%0d: rd=%h want %h", n, o_rd, e_rd); end
        n++;
      end
    end
    checks++; if (idx != 5 || n != 5) begin errors++; $display("FAIL bp_total: acc=%0d rsp=%0d want 5 5", idx, n); end
  endtask

  task automatic test_streaming();
    int n = 0, first = -1, last = -1, t0 = now, drops = 0;
    for (int i = 0; i < 22 && n < 16; i++) begin
      if (i < 16) tick(1'b0, 1'b1, 1'b0, 13'(i), 64'h0, 8'h00, 1'b1);
      else idle(1'b1);
      if (i < 16 && !o_acc) drops++;
      if (o_rv) begin
        if (first < 0) first = now - 1;
        last = now - 1;
        checks++; if (o_rwe !== 1'b0 || o_rd !== ref_mem[n]) begin
          errors++; $display("FAIL stream_rsp%0d: rd=%h want %h", n, o_rd, ref_mem[n]); end
        n++;
      end
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL stream_ready: drops=%0d want 0", drops); end
    checks++; if (n != 16 || last - first != 15 || first - t0 != 2) begin
      errors++; $display("FAIL stream_timing: n=%0d span=%0d lat=%0d want 16 15 2", n, last - first, first - t0); end
  endtask

  task automatic test_zero_be();
    int n = 0;
    tick(1'b0, 1'b1, 1'b1, 13'd3, 64'h01234567_89ABCDEF, 8'h00, 1'b1);
    checks++; if (o_acc !== 1'b1 || o_en !== 8'h00 || o_mwe !== 8'h00) begin
      errors++; $display("FAIL zbe_issue: acc=%b en=%h we=%h want 1 00 00", o_acc, o_en, o_mwe); end
    tick(1'b0, 1'b1, 1'b0, 13'd3, 64'h0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      if (o_rv) begin
        if (n == 0) begin
          checks++; if (o_rwe !== 1'b1 || o_rd !== 64'h0) begin errors++; $display("FAIL zbe_rsp: we=%b rd=%h want 1 0", o_rwe, o_rd); end
        end else begin
          checks++; if (o_rwe !== 1'b0 || o_rd !== PRE3) begin errors++; $display("FAIL zbe_ram: rd=%h want %h", o_rd, PRE3); end
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL zbe_count: got %0d want 2", n); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int i = 1; i <= 3; i++) tick(1'b0, 1'b1, 1'b0, 13'(i), 64'h0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 13'd0, 64'h0, 8'h00, 1'b0);
    checks++; if (o_rv !== 1'b1 || o_ready !== 1'b0) begin
      errors++; $display("FAIL rm_pre: v=%b ready=%b want 1 0", o_rv, o_ready); end
    idle(1'b1);
    checks++; if (o_rv !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL rm_post: v=%b ready=%b want 0 1", o_rv, o_ready); end
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (o_rv) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rm_stale: got %0d responses want 0", stale); end
  endtask

  task automatic test_random();
    logic v, we, rr;
    logic [12:0] a;
    logic [63:0] wd;
    logic [7:0] be, xen;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0); we = $urandom_range(0, 1) == 1;
      a = 13'($urandom_range(0, 15)); wd = {$urandom, $urandom}; be = 8'($urandom);
      rr = ($urandom_range(0, 2) != 0);
      tick(1'b0, v, we, a, wd, be, rr);
      xen = e_acc ? (we ? be : 8'hFF) : 8'h00;
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", now, o_ready, e_ready); end
      checks++; if (o_en !== xen || o_mwe !== (we ? xen : 8'h00)) begin
        errors++; $display("FAIL rnd_mem@%0d: en=%h we=%h want en=%h", now, o_en, o_mwe, xen); end
      if (e_acc) begin
        checks++; if (o_maddr !== a || (we && o_mwd !== wd)) begin
          errors++; $display("FAIL rnd_maddr@%0d: addr=%0d wd=%h want %0d %h", now, o_maddr, o_mwd, a, wd); end
      end
      checks++; if (o_rv !== e_rv) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", now, o_rv, e_rv); end
      if (o_rv && e_rv) begin
        checks++; if (o_rwe !== e_we || o_rd !== e_rd) begin
          errors++; $display("FAIL rnd_rsp@%0d: we=%b rd=%h want %b %h", now, o_rwe, o_rd, e_we, e_rd); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0;
    preload();
    test_reset();
    test_single_read();
    drain();
    test_byte_write();
    drain();
    test_backpressure();
    drain();
    test_streaming();
    drain();
    test_zero_be();
    drain();
    test_reset_mid();
    test_random();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
